// File: rtl/tdm_demux4_pkg.sv
// Shared constants for the TDM 4-slot receive demultiplexer.
// State encodings, frame geometry and slot indices matching the mux select.
package tdm_demux4_pkg;

  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  function automatic logic [1:0] next_sel(input logic [1:0] s);
    return (s == 2'(NUM_SLOTS - 1)) ? SLOT_A : s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_demux4_slot_tracker.sv
// Frame-alignment FSM and slot counter for the TDM demultiplexer.
// Emits per-slot capture strobes plus discard/resync indications.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_HUNT   | not aligned; valid samples dropped until one carries fsync
// ST_LOCKED | aligned; sel is the slot index of the next valid sample
module tdm_slot_tracker
  import tdm_demux4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic       fsync,
  output logic       cap0,
  output logic       cap1,
  output logic       cap2,
  output logic       cap3,
  output logic       discard,
  output logic       resync,
  output logic       locked,
  output logic [1:0] sel,
  output logic       sync_err
);

  logic       state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sync_err_d = 1'b0;
    cap0       = 1'b0;
    cap1       = 1'b0;
    cap2       = 1'b0;
    cap3       = 1'b0;
    discard    = 1'b0;
    resync     = 1'b0;
    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        if (fsync) begin
          cap0    = 1'b1;
          sel_d   = SLOT_B;
          state_d = ST_LOCKED;
        end else begin
          discard = 1'b1;
        end
      end else if (fsync) begin
        // fsync always restarts the frame; mid-frame it also flags misalignment
        cap0  = 1'b1;
        sel_d = SLOT_B;
        if (sel_q != SLOT_A) begin
          resync     = 1'b1;
          sync_err_d = 1'b1;
        end
      end else begin
        case (sel_q)
          SLOT_A: begin
            discard    = 1'b1;
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
            sel_d      = SLOT_A;
          end
          SLOT_B: begin
            cap1  = 1'b1;
            sel_d = next_sel(sel_q);
          end
          SLOT_C: begin
            cap2  = 1'b1;
            sel_d = next_sel(sel_q);
          end
          SLOT_D: begin
            cap3  = 1'b1;
            sel_d = next_sel(sel_q);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      sel_q      <= SLOT_A;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign locked   = (state_q == ST_LOCKED);
  assign sel      = sel_q;
  assign sync_err = sync_err_q;

endmodule

// File: rtl/tdm_demux4.sv
// TDM 4-slot receive demultiplexer: shadows slots 0..2, then publishes
// all four channels atomically on the edge that accepts slot 3.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       sel,
  output logic             sync_err
);

  logic cap0, cap1, cap2, cap3, discard, resync;

  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;

  tdm_slot_tracker u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .fsync    (fsync),
    .cap0     (cap0),
    .cap1     (cap1),
    .cap2     (cap2),
    .cap3     (cap3),
    .discard  (discard),
    .resync   (resync),
    .locked   (locked),
    .sel      (sel),
    .sync_err (sync_err)
  );

  always_comb begin
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    // drop any partial frame so stale slots never leak into a later publish
    if (discard || resync) begin
      sh1_d = '0;
      sh2_d = '0;
    end
    if (cap0) sh0_d = din;
    if (cap1) sh1_d = din;
    if (cap2) sh2_d = din;
    if (cap3) begin
      a_d           = sh0_q;
      b_d           = sh1_q;
      c_d           = sh2_q;
      d_d           = din;
      frame_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=8) with a frame-queue reference model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       fsync;
  logic [7:0] a, b, c, d;
  logic       frame_valid, locked, sync_err;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a, exp_b, exp_c, exp_d;
  logic       exp_fv, exp_se, exp_locked;
  logic [7:0] frm[$];

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
    .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid), .locked(locked),
    .sel(sel), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sel();
    return 2'(frm.size());
  endfunction

  task automatic model_reset();
    exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
    exp_fv = 0; exp_se = 0; exp_locked = 0;
    frm.delete();
  endtask

  // Reference: a frame is a list of samples starting at an fsync sample.
  task automatic model_step(input logic v, input logic fs, input logic [7:0] x);
    exp_fv = 0;
    exp_se = 0;
    if (!v) return;
    if (!exp_locked) begin
      if (fs) begin
        frm.delete(); frm.push_back(x); exp_locked = 1;
      end
    end else if (fs) begin
      if (frm.size() != 0) exp_se = 1;
      frm.delete(); frm.push_back(x);
    end else if (frm.size() == 0) begin
      exp_se = 1; exp_locked = 0;
    end else begin
      frm.push_back(x);
      if (frm.size() == 4) begin
        exp_a = frm[0]; exp_b = frm[1]; exp_c = frm[2]; exp_d = frm[3];
        exp_fv = 1;
        frm.delete();
      end
    end
  endtask

  task automatic drive(input logic v, input logic fs, input logic [7:0] x);
    @(negedge clk);
    din_valid = v; fsync = fs; din = x;
    @(posedge clk);
    model_step(v, fs, x);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; din_valid = 0; fsync = 0; din = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a, b, c, d} !== 32'h0 || frame_valid !== 0 || locked !== 0 || sel !== 0 || sync_err !== 0) begin
      errors++;
      $display("FAIL reset_state: a=%h b=%h c=%h d=%h fv=%b lk=%b sel=%0d se=%b, required all zero",
               a, b, c, d, frame_valid, locked, sel, sync_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_clean_frame();
    drive(1, 1, 8'h01);
    checks++;
    if (locked !== 1 || sel !== 2'd1) begin
      errors++; $display("FAIL clean_lock: locked=%b sel=%0d, required 1/1", locked, sel);
    end
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h01);
    drive(1, 0, 8'h01);
    checks++;
    if ({a, b, c, d} !== 32'h01000101 || frame_valid !== 1 || sel !== 0) begin
      errors++;
      $display("FAIL clean_publish: abcd=%h fv=%b sel=%0d, required 01000101/1/0", {a, b, c, d}, frame_valid, sel);
    end
    drive(0, 0, 8'h00);
    checks++;
    if (frame_valid !== 0) begin
      errors++; $display("FAIL clean_fv_pulse: fv=%b, required 0", frame_valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] smp [4];
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, smp[i]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          drive(0, 1, 8'hEE);
          checks++;
          if ({a, b, c, d} !== 32'h01000101 || frame_valid !== 0 || sel !== 2'(i + 1)) begin
            errors++;
            $display("FAIL gap_hold: abcd=%h fv=%b sel=%0d, required 01000101/0/%0d", {a, b, c, d}, frame_valid, sel, i + 1);
          end
        end
      end
    end
    checks++;
    if ({a, b, c, d} !== 32'h11223344 || frame_valid !== 1) begin
      errors++; $display("FAIL gap_publish: abcd=%h fv=%b, required 11223344/1", {a, b, c, d}, frame_valid);
    end
  endtask

  task automatic test_missing_fsync();
    drive(1, 1, 8'hA1); drive(1, 0, 8'hB2); drive(1, 0, 8'hC3); drive(1, 0, 8'hD4);
    checks++;
    if ({a, b, c, d} !== 32'hA1B2C3D4 || frame_valid !== 1) begin
      errors++; $display("FAIL missing_pre: abcd=%h fv=%b, required a1b2c3d4/1", {a, b, c, d}, frame_valid);
    end
    drive(1, 0, 8'h55);
    checks++;
    if (sync_err !== 1 || locked !== 0 || {a, b, c, d} !== 32'hA1B2C3D4 || frame_valid !== 0) begin
      errors++;
      $display("FAIL missing_err: se=%b lk=%b abcd=%h fv=%b, required 1/0/a1b2c3d4/0", sync_err, locked, {a, b, c, d}, frame_valid);
    end
    drive(1, 0, 8'h66);
    drive(1, 0, 8'h67);
    checks++;
    if (sync_err !== 0 || locked !== 0 || sel !== 0) begin
      errors++; $display("FAIL missing_hunt: se=%b lk=%b sel=%0d, required 0/0/0", sync_err, locked, sel);
    end
    drive(1, 1, 8'h10); drive(1, 0, 8'h20); drive(1, 0, 8'h30); drive(1, 0, 8'h40);
    checks++;
    if ({a, b, c, d} !== 32'h10203040 || frame_valid !== 1 || locked !== 1) begin
      errors++; $display("FAIL missing_recover: abcd=%h fv=%b lk=%b, required 10203040/1/1", {a, b, c, d}, frame_valid, locked);
    end
  endtask

  task automatic test_early_fsync();
    drive(1, 1, 8'h77); drive(1, 0, 8'h78);
    drive(1, 1, 8'h5A);
    checks++;
    if (sync_err !== 1 || locked !== 1 || frame_valid !== 0 || sel !== 1 || {a, b, c, d} !== 32'h10203040) begin
      errors++;
      $display("FAIL early_err: se=%b lk=%b fv=%b sel=%0d abcd=%h, required 1/1/0/1/10203040",
               sync_err, locked, frame_valid, sel, {a, b, c, d});
    end
    drive(1, 0, 8'h01); drive(1, 0, 8'h02); drive(1, 0, 8'h03);
    checks++;
    if ({a, b, c, d} !== 32'h5A010203 || frame_valid !== 1 || sync_err !== 0) begin
      errors++; $display("FAIL early_publish: abcd=%h fv=%b se=%b, required 5a010203/1/0", {a, b, c, d}, frame_valid, sync_err);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 8'h99); drive(1, 0, 8'h98);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a, b, c, d} !== 32'h0 || locked !== 0 || sel !== 0) begin
      errors++; $display("FAIL async_reset: abcd=%h lk=%b sel=%0d, required 0/0/0", {a, b, c, d}, locked, sel);
    end
    model_reset();
    @(negedge clk);
    din_valid = 0; fsync = 0;
    @(negedge clk);
    rst_n = 1;
    drive(1, 1, 8'hC0); drive(1, 0, 8'hC1); drive(1, 0, 8'hC2); drive(1, 0, 8'hC3);
    checks++;
    if ({a, b, c, d} !== 32'hC0C1C2C3 || frame_valid !== 1) begin
      errors++; $display("FAIL async_recover: abcd=%h fv=%b, required c0c1c2c3/1", {a, b, c, d}, frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, (i % 4) == 0, 8'($urandom));
      if (frame_valid) pulses++;
      checks++;
      if (frame_valid !== ((i % 4) == 3) || sync_err !== 0 || {a, b, c, d} !== {exp_a, exp_b, exp_c, exp_d}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: fv=%b se=%b abcd=%h, required %b/0/%h",
                 i, frame_valid, sync_err, {a, b, c, d}, (i % 4) == 3, {exp_a, exp_b, exp_c, exp_d});
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++; $display("FAIL b2b_pulses: got %0d, required 3", pulses);
    end
  endtask

  task automatic test_random();
    int pubs = 0;
    for (int i = 0; i < 600; i++) begin
      logic v, fs;
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 4) == 0) || (exp_sel() == 0 && $urandom_range(0, 2) != 0);
      drive(v, fs, 8'($urandom));
      if (exp_fv) pubs++;
      checks++;
      if ({a, b, c, d} !== {exp_a, exp_b, exp_c, exp_d} || frame_valid !== exp_fv || sync_err !== exp_se ||
          locked !== exp_locked || sel !== exp_sel()) begin
        errors++;
        $display("FAIL random_cycle%0d: abcd=%h fv=%b se=%b lk=%b sel=%0d, required %h/%b/%b/%b/%0d",
                 i, {a, b, c, d}, frame_valid, sync_err, locked, sel,
                 {exp_a, exp_b, exp_c, exp_d}, exp_fv, exp_se, exp_locked, exp_sel());
      end
    end
    checks++;
    if (pubs == 0) begin
      errors++; $display("FAIL random_coverage: publishes=%0d, required nonzero", pubs);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_gapped();
    test_missing_fsync();
    test_early_fsync();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
